id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register plus operand-forwarding and load-use hazard logic for the 16-bit core.
- Sits between decode/register-read and the 16-bit ALU (inputs a, b, ALUC[3:0], ALUB[1:0], Unsig).
- Captures decoded fields each cycle and resolves ALU operands against the MEM and WB stages.
- Inserts bubbles on load-use hazards and on flush.

Parameters:
- DW, 16, datapath width
- RW, 3, register address width (8 GPRs, r0 hardwired zero)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- stall  in  1  global pipeline freeze; stage holds its contents
- flush  in  1  squash decode instruction (taken branch)
- id_valid  in  1  decode slot holds an instruction
- id_rs1, id_rs2  in  RW  source register addresses
- id_use_rs1, id_use_rs2  in  1  instruction reads that source
- id_rd1, id_rd2  in  DW  register-file read data (file is write-through)
- id_imm  in  DW  sign/zero-extended immediate
- id_use_imm  in  1  b operand = immediate
- id_aluc  in  4  ALU opcode
- id_alub  in  2  branch condition
- id_unsig  in  1  unsigned compare
- id_rd  in  RW  destination register
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- mem_fwd_rd  in  RW  MEM stage destination
- mem_fwd_we  in  1  MEM stage writes register
- mem_fwd_data  in  DW  MEM stage ALU result
- wb_fwd_rd  in  RW  WB stage destination
- wb_fwd_we  in  1  WB stage writes register
- wb_fwd_data  in  DW  WB stage write data
- hazard_stall  out  1  load-use stall request to fetch/decode (combinational)
- ex_valid  out  1  stage holds a live instruction
- ex_a, ex_b  out  DW  forwarded ALU operands
- ex_store_data  out  DW  forwarded rs2 value (store data)
- ex_imm  out  DW  registered immediate (branch offset)
- ex_aluc  out  4  registered ALU opcode
- ex_alub  out  2  registered branch condition
- ex_unsig  out  1  registered Unsig
- ex_rd  out  RW  registered destination
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered controls, gated by ex_valid

Behaviour:
- Register update on posedge clk. Priority: reset > stall > flush > hazard bubble > load.
- Reset (rst_n=0 at edge): all registered fields 0, so ex_valid=0, ex_aluc=4'b0000 (ALU outputs 0), ex_alub=2'b00, all controls 0.
- Reset outranks stall and flush mid-operation.
- stall=1: every register holds, including ex_valid. hazard_stall is still computed.
- flush=1 (no stall): load a bubble.
- hazard_stall=1 (no stall, no flush): load a bubble. Decode is held upstream, so the consumer re-enters next cycle.
- Bubble: ex_valid=0, aluc=0, alub=0, all controls 0, data fields 0.
- Otherwise: capture id_* fields; ex_valid <= id_valid.
- hazard_stall = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- hazard_stall is forced 0 when flush=1.
- Forwarding is combinational on registered rs1/rs2. Operand X resolves as:
  - r0 -> 0
  - else MEM match (mem_fwd_we & mem_fwd_rd==X) -> mem_fwd_data
  - else WB match -> wb_fwd_data
  - else registered read data
  - MEM has priority over WB when both match.
- ex_a = resolved rs1.
- ex_store_data = resolved rs2.
- ex_b = ex_imm if registered use_imm, else resolved rs2.
- Total latency: 1 cycle from id_* to ex_* fields; operands valid in the same cycle as forward sources.

Test Plan:
- Reset: rst_n=0 one edge with id_valid=1, id_aluc=4'hC, stall=1 -> ex_valid=0, ex_aluc=0, ex_reg_write=0.
- Pass-through: id_rd1=16'h1234, id_use_imm=1, id_imm=16'hFFF0, id_aluc=4'hC -> next cycle ex_a=1234, ex_b=FFF0, ex_aluc=C, ex_valid=1.
- Forwarding priority: registered rs1=3, mem_fwd_rd=3/we=1/data=00AA, wb_fwd_rd=3/we=1/data=00BB -> ex_a=00AA. Drop mem we -> ex_a=00BB. With rs1=0 and both sources matching 0 -> ex_a=0000.
- Load-use: ex holds load with rd=2; decode id_rs2=2, id_use_rs2=1 -> hazard_stall=1, next ex_valid=0. Consumer then captured with ex_store_data taking mem_fwd_data.
- Flush vs stall: flush=1 -> next ex_valid=0, hazard_stall=0. flush=1 with stall=1 -> contents unchanged for every stalled cycle.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 16-bit core.
// Forwards ALU operands from MEM/WB and raises load-use stalls.
module id_ex_stage #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic          id_use_rs1,
  input  logic          id_use_rs2,
  input  logic [DW-1:0] id_rd1,
  input  logic [DW-1:0] id_rd2,
  input  logic [DW-1:0] id_imm,
  input  logic          id_use_imm,
  input  logic [3:0]    id_aluc,
  input  logic [1:0]    id_alub,
  input  logic          id_unsig,
  input  logic [RW-1:0] id_rd,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic [RW-1:0] mem_fwd_rd,
  input  logic          mem_fwd_we,
  input  logic [DW-1:0] mem_fwd_data,
  input  logic [RW-1:0] wb_fwd_rd,
  input  logic          wb_fwd_we,
  input  logic [DW-1:0] wb_fwd_data,
  output logic          hazard_stall,
  output logic          ex_valid,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_store_data,
  output logic [DW-1:0] ex_imm,
  output logic [3:0]    ex_aluc,
  output logic [1:0]    ex_alub,
  output logic          ex_unsig,
  output logic [RW-1:0] ex_rd,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write
);

  logic          valid_q;
  logic [RW-1:0] rs1_q;
  logic [RW-1:0] rs2_q;
  logic [DW-1:0] rd1_q;
  logic [DW-1:0] rd2_q;
  logic [DW-1:0] imm_q;
  logic          use_imm_q;
  logic [3:0]    aluc_q;
  logic [1:0]    alub_q;
  logic          unsig_q;
  logic [RW-1:0] rd_q;
  logic          rw_q;
  logic          mr_q;
  logic          mw_q;

  logic          hit1;
  logic          hit2;
  logic          bubble;
  logic [DW-1:0] op1;
  logic [DW-1:0] op2;

  assign hit1 = id_use_rs1 & (id_rs1 == rd_q);
  assign hit2 = id_use_rs2 & (id_rs2 == rd_q);

  assign hazard_stall = ~flush & id_valid & valid_q & mr_q
                      & (rd_q != '0) & (hit1 | hit2);

  assign bubble = flush | hazard_stall;

  // Pipeline register: reset > stall > bubble > load
  always_ff @(posedge clk) begin
    if (!rst_n || (!stall && bubble)) begin
      valid_q   <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      aluc_q    <= '0;
      alub_q    <= '0;
      unsig_q   <= 1'b0;
      rd_q      <= '0;
      rw_q      <= 1'b0;
      mr_q      <= 1'b0;
      mw_q      <= 1'b0;
    end else if (!stall) begin
      valid_q   <= id_valid;
      rs1_q     <= id_rs1;
      rs2_q     <= id_rs2;
      rd1_q     <= id_rd1;
      rd2_q     <= id_rd2;
      imm_q     <= id_imm;
      use_imm_q <= id_use_imm;
      aluc_q    <= id_aluc;
      alub_q    <= id_alub;
      unsig_q   <= id_unsig;
      rd_q      <= id_rd;
      rw_q      <= id_reg_write;
      mr_q      <= id_mem_read;
      mw_q      <= id_mem_write;
    end
  end

  // Operand resolve: r0, then MEM, then WB, then file data
  always_comb begin
    op1 = rd1_q;
    if (rs1_q == '0)
      op1 = '0;
    else if (mem_fwd_we && mem_fwd_rd == rs1_q)
      op1 = mem_fwd_data;
    else if (wb_fwd_we && wb_fwd_rd == rs1_q)
      op1 = wb_fwd_data;
  end

  // Same resolve for rs2
  always_comb begin
    op2 = rd2_q;
    if (rs2_q == '0)
      op2 = '0;
    else if (mem_fwd_we && mem_fwd_rd == rs2_q)
      op2 = mem_fwd_data;
    else if (wb_fwd_we && wb_fwd_rd == rs2_q)
      op2 = wb_fwd_data;
  end

  assign ex_valid      = valid_q;
  assign ex_a          = op1;
  assign ex_store_data = op2;
  assign ex_b          = use_imm_q ? imm_q : op2;
  assign ex_imm        = imm_q;
  assign ex_aluc       = aluc_q;
  assign ex_alub       = alub_q;
  assign ex_unsig      = unsig_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = rw_q & valid_q;
  assign ex_mem_read   = mr_q & valid_q;
  assign ex_mem_write  = mw_q & valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vectors, a reference
// model checked every cycle, plus literal expectations.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, id_valid;
  logic [2:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_use_imm, id_unsig;
  logic [15:0] id_rd1, id_rd2, id_imm;
  logic [3:0]  id_aluc;
  logic [1:0]  id_alub;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic [2:0]  mem_fwd_rd, wb_fwd_rd;
  logic        mem_fwd_we, wb_fwd_we;
  logic [15:0] mem_fwd_data, wb_fwd_data;
  logic        hazard_stall, ex_valid;
  logic [15:0] ex_a, ex_b, ex_store_data, ex_imm;
  logic [3:0]  ex_aluc;
  logic [1:0]  ex_alub;
  logic        ex_unsig;
  logic [2:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(16), .RW(3)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_aluc(id_aluc),
    .id_alub(id_alub), .id_unsig(id_unsig), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write),
    .mem_fwd_rd(mem_fwd_rd), .mem_fwd_we(mem_fwd_we),
    .mem_fwd_data(mem_fwd_data),
    .wb_fwd_rd(wb_fwd_rd), .wb_fwd_we(wb_fwd_we),
    .wb_fwd_data(wb_fwd_data),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid),
    .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
    .ex_imm(ex_imm), .ex_aluc(ex_aluc), .ex_alub(ex_alub),
    .ex_unsig(ex_unsig), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write)
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Reference: what instruction currently sits in EX
  typedef struct packed {
    logic        v;
    logic [2:0]  rs1, rs2, rd;
    logic [15:0] d1, d2, imm;
    logic        ui;
    logic [3:0]  aluc;
    logic [1:0]  alub;
    logic        un, rw, mr, mw;
  } slot_t;

  slot_t m;
  bit    started = 0;

  function automatic logic m_haz();
    logic reads;
    reads = (id_use_rs1 && id_rs1 == m.rd)
         || (id_use_rs2 && id_rs2 == m.rd);
    return !flush && id_valid && m.v && m.mr
        && m.rd != 0 && reads;
  endfunction

  function automatic logic [15:0] value_of(
      input logic [2:0] r, input logic [15:0] file_val);
    if (r == 0) return 16'h0;
    if (mem_fwd_we && mem_fwd_rd == r) return mem_fwd_data;
    if (wb_fwd_we && wb_fwd_rd == r) return wb_fwd_data;
    return file_val;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) m = '0;
    else if (stall) m = m;
    else if (flush || m_haz()) m = '0;
    else begin
      m.v    = id_valid;
      m.rs1  = id_rs1;
      m.rs2  = id_rs2;
      m.rd   = id_rd;
      m.d1   = id_rd1;
      m.d2   = id_rd2;
      m.imm  = id_imm;
      m.ui   = id_use_imm;
      m.aluc = id_aluc;
      m.alub = id_alub;
      m.un   = id_unsig;
      m.rw   = id_reg_write & id_valid;
      m.mr   = id_mem_read & id_valid;
      m.mw   = id_mem_write & id_valid;
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      logic [15:0] b_exp;
      b_exp = m.ui ? m.imm : value_of(m.rs2, m.d2);
      check("m_hazard", hazard_stall, m_haz());
      check("m_valid", ex_valid, m.v);
      check("m_a", ex_a, value_of(m.rs1, m.d1));
      check("m_b", ex_b, b_exp);
      check("m_sd", ex_store_data, value_of(m.rs2, m.d2));
      check("m_imm", ex_imm, m.imm);
      check("m_aluc", ex_aluc, m.aluc);
      check("m_alub", ex_alub, m.alub);
      check("m_unsig", ex_unsig, m.un);
      check("m_rd", ex_rd, m.rd);
      check("m_rw", ex_reg_write, m.rw);
      check("m_mr", ex_mem_read, m.mr);
      check("m_mw", ex_mem_write, m.mw);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; stall = 1; flush = 0; id_valid = 1;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_use_imm = 0;
    id_unsig = 0; id_rd1 = 0; id_rd2 = 0; id_imm = 0;
    id_aluc = 4'hC; id_alub = 0;
    id_reg_write = 1; id_mem_read = 0; id_mem_write = 0;
    mem_fwd_rd = 0; mem_fwd_we = 0; mem_fwd_data = 0;
    wb_fwd_rd = 0; wb_fwd_we = 0; wb_fwd_data = 0;

    tick();
    @(negedge clk);
    check("rst_valid", ex_valid, 0);
    check("rst_aluc", ex_aluc, 0);
    check("rst_rw", ex_reg_write, 0);

    rst_n = 1; stall = 0;
    id_rs1 = 1; id_use_rs1 = 1; id_rd1 = 16'h1234;
    id_use_imm = 1; id_imm = 16'hFFF0; id_rd = 4;
    id_alub = 2'b10; id_unsig = 1;
    tick();
    @(negedge clk);
    check("pt_a", ex_a, 16'h1234);
    check("pt_b", ex_b, 16'hFFF0);
    check("pt_aluc", ex_aluc, 4'hC);
    check("pt_valid", ex_valid, 1);

    id_rs1 = 3; id_rd1 = 16'h0111; id_use_imm = 0;
    id_rs2 = 5; id_rd2 = 16'h0555; id_aluc = 4'h2;
    tick();
    mem_fwd_rd = 3; mem_fwd_we = 1; mem_fwd_data = 16'h00AA;
    wb_fwd_rd = 3; wb_fwd_we = 1; wb_fwd_data = 16'h00BB;
    @(negedge clk);
    check("fw_mem", ex_a, 16'h00AA);
    check("fw_b_file", ex_b, 16'h0555);
    mem_fwd_we = 0;
    @(negedge clk);
    check("fw_wb", ex_a, 16'h00BB);

    id_rs1 = 0; id_rd1 = 16'h0777;
    tick();
    mem_fwd_rd = 0; mem_fwd_we = 1;
    wb_fwd_rd = 0;
    @(negedge clk);
    check("fw_r0", ex_a, 16'h0000);

    mem_fwd_we = 0; wb_fwd_we = 0;
    id_use_rs1 = 0; id_rs2 = 0; id_use_rs2 = 0;
    id_rd = 2; id_mem_read = 1; id_reg_write = 1;
    id_mem_write = 0;
    tick();
    id_rs2 = 2; id_use_rs2 = 1; id_rd2 = 16'h0222;
    id_mem_read = 0; id_reg_write = 0;
    id_mem_write = 1; id_rd = 0;
    @(negedge clk);
    check("lu_haz", hazard_stall, 1);
    tick();
    @(negedge clk);
    check("lu_bubble", ex_valid, 0);
    check("lu_haz_clr", hazard_stall, 0);
    mem_fwd_rd = 2; mem_fwd_we = 1; mem_fwd_data = 16'hBEEF;
    tick();
    @(negedge clk);
    check("lu_sd", ex_store_data, 16'hBEEF);
    check("lu_mw", ex_mem_write, 1);

    mem_fwd_we = 0;
    id_use_rs2 = 0; id_rd = 2; id_mem_read = 1;
    id_reg_write = 1; id_mem_write = 0;
    tick();
    id_use_rs2 = 1; id_mem_read = 0; id_reg_write = 0;
    id_mem_write = 1; id_rd = 0; flush = 1;
    @(negedge clk);
    check("fl_haz", hazard_stall, 0);
    tick();
    @(negedge clk);
    check("fl_valid", ex_valid, 0);
    flush = 0;

    id_rs1 = 6; id_use_rs1 = 1; id_rd1 = 16'h4242;
    id_aluc = 4'h5; id_rs2 = 0; id_use_rs2 = 0;
    id_rd = 1; id_mem_write = 0;
    tick();
    stall = 1; flush = 1; id_rd1 = 16'hDEAD; id_aluc = 4'h9;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("st_a", ex_a, 16'h4242);
      check("st_aluc", ex_aluc, 4'h5);
      check("st_valid", ex_valid, 1);
    end

    rst_n = 0;
    tick();
    @(negedge clk);
    check("rst2_valid", ex_valid, 0);
    check("rst2_aluc", ex_aluc, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
